// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M shift-add multiply / restoring divide unit driving the mul CDB lane
module mul_div_unit #(
  parameter int ROB_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [2:0]               issue_multop,
  input  logic [31:0]              issue_rs1_data,
  input  logic [31:0]              issue_rs2_data,
  input  logic [4:0]               issue_rd_addr,
  input  logic [ROB_IDX_WIDTH-1:0] issue_rob_idx,
  output logic                     cdb_mul_valid,
  output logic [31:0]              cdb_mul_data,
  output logic [4:0]               cdb_mul_rd_addr,
  output logic [ROB_IDX_WIDTH-1:0] cdb_mul_rob_idx
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t                   state_q;
  logic [2:0]               op_q;
  logic [4:0]               rd_q;
  logic [ROB_IDX_WIDTH-1:0] rob_q;
  logic                     neg_q, sa_q;
  logic [63:0]              acc_q, mc_q;
  logic [31:0]              mp_q;
  logic [5:0]               cnt_q;
  logic        accept, a_sgn, b_sgn, a_neg, b_neg, is_div, is_rem, div0, ovf;
  logic [31:0] a_mag, b_mag, spec_res, mul_res, div_res, rem_d, quot_d, iter_res;
  logic [63:0] mul_acc_d, prod_d;
  logic [33:0] diff_d;
  logic        ge_d;
  assign issue_ready   = (state_q == IDLE || state_q == DONE) && !flush;
  assign cdb_mul_valid = (state_q == DONE) && !flush;
  assign accept   = issue_valid && issue_ready;
  assign a_sgn    = issue_multop == 3'd1 || issue_multop == 3'd2 || issue_multop == 3'd4 || issue_multop == 3'd6;
  assign b_sgn    = issue_multop == 3'd1 || issue_multop == 3'd4 || issue_multop == 3'd6;
  assign a_neg    = a_sgn && issue_rs1_data[31];
  assign b_neg    = b_sgn && issue_rs2_data[31];
  assign a_mag    = a_neg ? -issue_rs1_data : issue_rs1_data;
  assign b_mag    = b_neg ? -issue_rs2_data : issue_rs2_data;
  assign is_div   = issue_multop[2];
  assign is_rem   = issue_multop[1];
  assign div0     = is_div && issue_rs2_data == 32'd0;
  // Signed overflow case (INT_MIN / -1) only applies to DIV/REM, not the unsigned forms
  assign ovf      = is_div && !issue_multop[0] && issue_rs1_data == 32'h8000_0000 && issue_rs2_data == 32'hFFFF_FFFF;
  assign spec_res = div0 ? (is_rem ? issue_rs1_data : 32'hFFFF_FFFF) : (is_rem ? 32'd0 : 32'h8000_0000);
  assign mul_acc_d = acc_q + (mp_q[0] ? mc_q : 64'd0);
  assign prod_d    = neg_q ? -mul_acc_d : mul_acc_d;
  assign mul_res   = op_q == 3'd0 ? prod_d[31:0] : prod_d[63:32];
  // Divide: acc_q holds {remainder, dividend/quotient}; shift in next dividend bit and trial-subtract
  assign diff_d  = {1'b0, acc_q[63:31]} - {2'b0, mc_q[31:0]};
  assign ge_d    = !diff_d[33];
  assign rem_d   = ge_d ? diff_d[31:0] : acc_q[62:31];
  assign quot_d  = {acc_q[30:0], ge_d};
  assign div_res = op_q[1] ? (sa_q ? -rem_d : rem_d) : (neg_q ? -quot_d : quot_d);
  assign iter_res = state_q == DIV ? div_res : mul_res;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      op_q            <= '0;
      rd_q            <= '0;
      rob_q           <= '0;
      neg_q           <= 1'b0;
      sa_q            <= 1'b0;
      acc_q           <= '0;
      mc_q            <= '0;
      mp_q            <= '0;
      cnt_q           <= '0;
      cdb_mul_data    <= '0;
      cdb_mul_rd_addr <= '0;
      cdb_mul_rob_idx <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else if (accept) begin
      op_q  <= issue_multop;
      rd_q  <= issue_rd_addr;
      rob_q <= issue_rob_idx;
      neg_q <= a_neg ^ b_neg;
      sa_q  <= a_neg;
      cnt_q <= '0;
      acc_q <= is_div ? {32'd0, a_mag} : 64'd0;
      mc_q  <= {32'd0, is_div ? b_mag : a_mag};
      mp_q  <= b_mag;
      state_q <= (div0 || ovf) ? DONE : (is_div ? DIV : MUL);
      if (div0 || ovf) begin
        cdb_mul_data    <= issue_rd_addr == 5'd0 ? 32'd0 : spec_res;
        cdb_mul_rd_addr <= issue_rd_addr;
        cdb_mul_rob_idx <= issue_rob_idx;
      end
    end else if (state_q == DONE) begin
      state_q <= IDLE;
    end else if (state_q == MUL || state_q == DIV) begin
      cnt_q <= cnt_q + 6'd1;
      acc_q <= state_q == DIV ? {rem_d, quot_d} : mul_acc_d;
      mc_q  <= state_q == DIV ? mc_q : {mc_q[62:0], 1'b0};
      mp_q  <= {1'b0, mp_q[31:1]};
      if (cnt_q == 6'd31) begin
        state_q         <= DONE;
        cdb_mul_data    <= rd_q == 5'd0 ? 32'd0 : iter_res;
        cdb_mul_rd_addr <= rd_q;
        cdb_mul_rob_idx <= rob_q;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed scoreboard bench for mul_div_unit
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_multop = '0;
  logic [31:0] issue_rs1_data = '0;
  logic [31:0] issue_rs2_data = '0;
  logic [4:0]  issue_rd_addr = '0;
  logic [4:0]  issue_rob_idx = '0;
  logic        cdb_mul_valid;
  logic [31:0] cdb_mul_data;
  logic [4:0]  cdb_mul_rd_addr;
  logic [4:0]  cdb_mul_rob_idx;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic [4:0]  rob;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  mul_div_unit #(.ROB_IDX_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_multop(issue_multop),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issue_rd_addr(issue_rd_addr), .issue_rob_idx(issue_rob_idx),
    .cdb_mul_valid(cdb_mul_valid), .cdb_mul_data(cdb_mul_data),
    .cdb_mul_rd_addr(cdb_mul_rd_addr), .cdb_mul_rob_idx(cdb_mul_rob_idx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    longint unsigned p;
    logic [63:0] r;
    case (op)
      3'd0: begin r = 64'(sa * sb); return r[31:0]; end
      3'd1: begin r = 64'(sa * sb); return r[63:32]; end
      3'd2: begin r = 64'(sa * ub); return r[63:32]; end
      3'd3: begin p = longint'(ua) * longint'(ub); r = p; return r[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  always @(negedge clk) begin
    if (!rst && cdb_mul_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_cdb_valid_rob", {59'd0, cdb_mul_rob_idx}, 64'h1F_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cdb_data", cdb_mul_data, e.d);
        chk("cdb_rd", cdb_mul_rd_addr, e.rd);
        chk("cdb_rob", cdb_mul_rob_idx, e.rob);
        chk("cdb_cycle", cyc, e.cyc);
      end
    end
  end
  // Presents one op for a single cycle; returns one cycle after acceptance
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [4:0] rob, input logic [31:0] exp,
                       input int lat, input bit push);
    exp_t e;
    issue_valid = 1'b1; issue_multop = op; issue_rs1_data = a; issue_rs2_data = b;
    issue_rd_addr = rd; issue_rob_idx = rob;
    e.d = rd == 0 ? 32'd0 : exp; e.rd = rd; e.rob = rob; e.cyc = cyc + lat;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [4:0] rob, input logic [31:0] exp, input int lat);
    issue(op, a, b, rd, rob, exp, lat, 1'b1);
    drain();
  endtask
  initial begin
    #2;
    chk("rst_valid", cdb_mul_valid, 0);
    chk("rst_data", cdb_mul_data, 0);
    chk("rst_rd", cdb_mul_rd_addr, 0);
    chk("rst_rob", cdb_mul_rob_idx, 0);
    chk("rst_ready", issue_ready, 1);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 5'd1, 32'hFFFF_FFEB, 33, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      chk("busy_ready_low", issue_ready, 0);
      @(posedge clk); #1;
    end
    drain();
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 5'd2, 32'h4000_0000, 33);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 5'd3, 32'hFFFF_FFFE, 33);
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 5'd4, 32'hFFFF_FFFF, 33);
    run(3'd4, -32'sd7, 32'd2, 5'd5, 5'd5, 32'hFFFF_FFFD, 33);
    run(3'd6, -32'sd7, 32'd2, 5'd6, 5'd6, 32'hFFFF_FFFF, 33);
    run(3'd7, 32'd100, 32'd7, 5'd7, 5'd7, 32'd2, 33);
    run(3'd5, 32'd5, 32'd0, 5'd8, 5'd8, 32'hFFFF_FFFF, 1);
    run(3'd6, 32'd5, 32'd0, 5'd9, 5'd9, 32'd5, 1);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 5'd10, 32'h8000_0000, 1);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 5'd11, 32'd0, 1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op; logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      run(op, a, b, 5'(12 + i), 5'(12 + i), ref_model(op, a, b), (op[2] && (b == 0)) ? 1 : 33);
    end
    // back-to-back: second op presented in the DONE cycle of the first, with rd=0
    issue(3'd0, 32'd123, 32'd456, 5'd20, 5'd20, 32'd56088, 33, 1'b1);
    repeat (32) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("b2b_ready_in_done", issue_ready, 1);
    chk("b2b_valid_in_done", cdb_mul_valid, 1);
    #4;
    issue(3'd5, 32'd1000, 32'd10, 5'd0, 5'd21, 32'd100, 33, 1'b1);
    drain();
    // flush at T+10 of a DIV: no broadcast for rob 22
    issue(3'd4, 32'd999, 32'd3, 5'd22, 5'd22, 32'd333, 33, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_low", issue_ready, 0);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("post_flush_ready", issue_ready, 1);
    repeat (40) begin @(posedge clk); #1; end
    chk("flush_no_result", sb.size(), 0);
    // async reset mid-MUL
    issue(3'd0, 32'd9, 32'd9, 5'd23, 5'd23, 32'd81, 33, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("arst_valid", cdb_mul_valid, 0);
    chk("arst_data", cdb_mul_data, 0);
    chk("arst_rd", cdb_mul_rd_addr, 0);
    chk("arst_rob", cdb_mul_rob_idx, 0);
    chk("arst_ready", issue_ready, 1);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    run(3'd0, 32'd6, 32'd7, 5'd24, 5'd24, 32'd42, 33);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M execution unit fed by the multiply/divide reservation station's issue output.
- Accepts one issued op at a time, runs a 1-bit-per-cycle shift-add multiply or restoring divide, and drives the mul lane of the CDB (valid/data/rd_addr/rob_idx).
- Back-pressures the reservation station through issue_ready while busy.

Parameters:
ROB_IDX_WIDTH, 5, width of ROB index tag carried through to CDB

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous squash (mispredict); kills in-flight op
issue_valid  input  1  issued op present (rs1/rs2 already ready)
issue_ready  output  1  unit can accept an op this cycle
issue_multop  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
issue_rs1_data  input  32  operand a
issue_rs2_data  input  32  operand b
issue_rd_addr  input  5  destination arch register
issue_rob_idx  input  ROB_IDX_WIDTH  destination ROB tag
cdb_mul_valid  output  1  one-cycle result broadcast
cdb_mul_data  output  32  result
cdb_mul_rd_addr  output  5  destination register of result
cdb_mul_rob_idx  output  ROB_IDX_WIDTH  ROB tag of result

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All data/tag/counter registers clear to 0; cdb_mul_valid=0, data/rd_addr/rob_idx=0.
  - issue_ready=1 (combinational from IDLE).
- States: IDLE, MUL, DIV, DONE.
- issue_ready = (state==IDLE || state==DONE) && !flush.
- Accept = issue_valid && issue_ready.
- On accept, latch multop, rd_addr, rob_idx, and sign flags:
  - a is signed for MULH, MULHSU, DIV, REM.
  - b is signed for MULH, DIV, REM.
- Operand conditioning: latch magnitudes |a| and |b|. result_neg is:
  - sign(a) XOR sign(b) for multiply and quotient.
  - sign(a) for remainder.
- Multiply (MUL state), 64-bit accumulator:
  - Iterates exactly 32 cycles.
  - Each cycle: if multiplier LSB is 1, add multiplicand at the current shift; shift; 6-bit counter increments; leave state when counter hits 31.
  - Final product is negated (two's complement, 64-bit) if result_neg.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide (DIV state), restoring, on magnitudes:
  - 32 iterations; each shifts remainder left by 1 with the next dividend bit, subtracts the divisor if non-negative, and sets the quotient bit.
  - Quotient is negated if result_neg; remainder is negated if sign(a) is set (signed ops only).
- Special cases skip iteration (accept cycle -> DONE):
  - b==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
  - Signed overflow, a==0x80000000 and b==0xFFFFFFFF for DIV/REM: DIV -> 0x80000000, REM -> 0.
- Latency (accept at cycle T):
  - Normal op: result is registered at the end of cycle T+32; state==DONE and cdb_mul_valid=1 during cycle T+33.
  - Special case: cdb_mul_valid=1 during cycle T+1.
- DONE:
  - cdb_mul_valid=1 for exactly one cycle; data/rd_addr/rob_idx are stable that cycle.
  - Next state is MUL/DIV/DONE if an op is accepted in the same cycle (back-to-back), else IDLE.
  - The CDB lane has no backpressure; the result is never held.
- cdb_mul_valid = (state==DONE) && !flush.
- rd_addr==0: the op still broadcasts (ROB needs completion) with cdb_mul_data forced to 0.
- Flush:
  - Any state -> IDLE next cycle.
  - Suppresses cdb_mul_valid in the flush cycle.
  - An issue presented during flush is not accepted.
  - Flush has priority over accept and over iteration.
- Reset mid-operation: immediate abort to IDLE, no broadcast.
- Outputs other than cdb_mul_valid hold their last value in IDLE and never change mid-iteration (registered on entry to DONE only).

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), accept at T -> cdb_mul_valid only at T+33, data=0xFFFFFFEB, issue_ready=0 during T+1..T+32.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF; REMU a=100, b=7 -> 2; all at T+33.
- DIVU a=5, b=0 -> 0xFFFFFFFF at T+1; REM a=5, b=0 -> 5 at T+1; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at T+1; REM of the same operands -> 0 at T+1.
- Back-to-back: second op presented during the DONE cycle is accepted (issue_ready=1 there); the first result broadcasts with its own rob_idx and the second follows 33 cycles later; rd_addr=0 op broadcasts data=0.
- Flush at T+10 of a DIV -> no cdb_mul_valid ever for that tag, issue_ready=1 at T+11; async rst asserted mid-MUL -> outputs 0 immediately, next op completes normally.
